// File: rtl/row_accumulator_pkg.sv
// -----------------------------------------------------------------------------
// row_accumulator_pkg
//   Shared types for the row accumulator slice.
//   flags_t     : beat flags coming alongside each adder-tree partial sum.
//   acc_state_e : row-framing FSM state (no open row / row open).
// The row result struct depends on the top's width parameters, so it is
// declared in the module that owns those parameters.
// -----------------------------------------------------------------------------
package row_accumulator_pkg;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } flags_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_e;

endpackage

// File: rtl/row_accumulator_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO holding completed row results.
//   Ports:
//     clk, resetn   clock, synchronous active-low reset (empties the FIFO)
//     i_push/i_wdata write request and data (ignored when full)
//     i_pop          read request (ignored when empty)
//     o_rdata        head entry; all-zero while empty
//     o_full/o_empty occupancy flags
//     o_count        number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_push_en;
    logic w_pop_en;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_push_en = i_push && !o_full;
    assign w_pop_en  = i_pop && !o_empty;

    // Head is forced to zero while empty so the outputs read zero after reset
    // without having to clear the storage array.
    assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;   // DEPTH is a power of two: natural wrap
            end
            if (w_pop_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_en, w_pop_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_en) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/row_accumulator.sv
// -----------------------------------------------------------------------------
// row_accumulator
//   Sums the adder tree's per-beat partial sums over a framed row
//   (first .. last) and queues each finished row in a small output FIFO.
//   Ports:
//     clk, resetn   clock, synchronous active-low reset
//     in_data       signed partial sum for this beat
//     in_flags      {valid, first, last} beat flags
//     in_ready      beat accepted when in_flags.valid && in_ready (= FIFO not full)
//     out_sum       row sum at FIFO head (signed, clamped or wrapped)
//     out_beats     beats in the row, saturating at 2^CNT_WIDTH-1
//     out_ovf       an add overflowed somewhere in the row
//     out_valid     FIFO non-empty
//     out_ready     pop head when out_valid && out_ready
//     proto_err     one-cycle pulse on a framing violation
// -----------------------------------------------------------------------------
module row_accumulator
    import row_accumulator_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int CNT_WIDTH  = 8,
    parameter int OUT_DEPTH  = 4,
    parameter bit SATURATE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  flags_t                in_flags,
    output logic                  in_ready,
    output logic [ACC_WIDTH-1:0]  out_sum,
    output logic [CNT_WIDTH-1:0]  out_beats,
    output logic                  out_ovf,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  proto_err
);

    typedef struct packed {
        logic [ACC_WIDTH-1:0] sum;
        logic [CNT_WIDTH-1:0] beats;
        logic                 ovf;
    } row_result_t;

    localparam int RES_W = $bits(row_result_t);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    acc_state_e                  r_state;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic [CNT_WIDTH-1:0]        r_beats;
    logic                        r_ovf;
    logic                        r_proto_err;

    logic                        w_accept;
    logic signed [DATA_WIDTH-1:0] w_in_s;
    logic signed [ACC_WIDTH-1:0] w_x;
    logic signed [ACC_WIDTH:0]   w_sum_wide;
    logic                        w_add_ovf;
    logic [ACC_WIDTH-1:0]        w_sum_res;
    logic [CNT_WIDTH-1:0]        w_beats_inc;
    logic                        w_push;
    row_result_t                 w_push_data;
    row_result_t                 w_head;
    logic                        w_full;
    logic                        w_empty;
    logic [$clog2(OUT_DEPTH):0]  w_count;

    // Backpressure straight from occupancy, no look-ahead on a same-cycle pop.
    assign in_ready = (w_count < ($clog2(OUT_DEPTH)+1)'(OUT_DEPTH));
    assign w_accept = in_flags.valid && in_ready;

    assign w_in_s = in_data;
    assign w_x    = ACC_WIDTH'(w_in_s);

    // One extra bit of headroom: overflow iff the top two bits disagree.
    assign w_sum_wide = (ACC_WIDTH+1)'(r_acc) + (ACC_WIDTH+1)'(w_x);
    assign w_add_ovf  = w_sum_wide[ACC_WIDTH] ^ w_sum_wide[ACC_WIDTH-1];

    always_comb begin
        w_sum_res = w_sum_wide[ACC_WIDTH-1:0];
        if (SATURATE && w_add_ovf) begin
            w_sum_res = w_sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end

    assign w_beats_inc = (&r_beats) ? r_beats : r_beats + 1'b1;

    // A beat carrying 'first' always starts a fresh row, whatever the state;
    // only a continuation beat in an open row adds to the accumulator.
    always_comb begin
        w_push      = 1'b0;
        w_push_data = '0;
        if (w_accept && in_flags.last) begin
            if (in_flags.first) begin
                w_push      = 1'b1;
                w_push_data = '{sum: w_x, beats: CNT_WIDTH'(1), ovf: 1'b0};
            end else if (r_state == ACCUM) begin
                w_push      = 1'b1;
                w_push_data = '{sum: w_sum_res, beats: w_beats_inc, ovf: r_ovf | w_add_ovf};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_beats     <= '0;
            r_ovf       <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_proto_err <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    IDLE: begin
                        if (!in_flags.first) begin
                            r_proto_err <= 1'b1;       // orphan continuation beat: dropped
                        end else if (!in_flags.last) begin
                            r_acc   <= w_x;
                            r_beats <= CNT_WIDTH'(1);
                            r_ovf   <= 1'b0;
                            r_state <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        if (in_flags.first) begin
                            // Restart: the unfinished row is thrown away.
                            r_proto_err <= 1'b1;
                            if (in_flags.last) begin
                                r_state <= IDLE;
                            end else begin
                                r_acc   <= w_x;
                                r_beats <= CNT_WIDTH'(1);
                                r_ovf   <= 1'b0;
                            end
                        end else begin
                            r_acc   <= w_sum_res;
                            r_beats <= w_beats_inc;
                            r_ovf   <= r_ovf | w_add_ovf;
                            if (in_flags.last) begin
                                r_state <= IDLE;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    sync_fifo #(
        .WIDTH (RES_W),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push && !w_full),
        .i_wdata (w_push_data),
        .i_pop   (out_ready),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign out_valid = !w_empty;
    assign out_sum   = w_head.sum;
    assign out_beats = w_head.beats;
    assign out_ovf   = w_head.ovf;
    assign proto_err = r_proto_err;

endmodule
